// File: rtl/obi_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : obi_mem_arbiter
// Description : Round-robin arbiter sharing one OBI memory port between
//               NUM_MASTERS core-side OBI masters. A stability lock holds
//               the address phase until it is granted, and an ID FIFO
//               routes in-order responses back to the issuing master.
// Revision    : 1.0 - initial release
// ============================================================================
module obi_mem_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NUM_MASTERS-1:0]                m_req_i,
  input  logic [NUM_MASTERS-1:0]                m_we_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   m_be_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_wdata_i,
  output logic [NUM_MASTERS-1:0]                m_gnt_o,
  output logic [NUM_MASTERS-1:0]                m_rvalid_o,
  output logic [DATA_WIDTH-1:0]                 m_rdata_o,
  output logic                                  s_req_o,
  output logic                                  s_we_o,
  output logic [DATA_WIDTH/8-1:0]               s_be_o,
  output logic [ADDR_WIDTH-1:0]                 s_addr_o,
  output logic [DATA_WIDTH-1:0]                 s_wdata_o,
  input  logic                                  s_gnt_i,
  input  logic                                  s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                 s_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o,
  output logic                                  err_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int ID_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_MASTERS - 1);

  // Registered state
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [ID_W-1:0]  lock_idx_q, lock_idx_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic [ID_W-1:0]  fifo_q [MAX_OUTSTANDING];

  // Combinational helpers
  logic [ADDR_WIDTH-1:0]    w_addr  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]    w_wdata [NUM_MASTERS];
  logic [BE_WIDTH-1:0]      w_be    [NUM_MASTERS];
  logic [2*NUM_MASTERS-1:0] w_req_dbl;
  logic                     w_rr_found;
  logic [ID_W-1:0]          w_rr_idx;
  logic [ID_W-1:0]          w_winner;
  logic [ID_W-1:0]          w_head;
  logic                     w_full;
  logic                     w_hs;
  logic                     w_pop;
  logic                     w_spurious;
  logic                     w_drop;

  // Split the packed per-master buses into indexable arrays
  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign w_addr[g]  = m_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[g] = m_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_be[g]    = m_be_i[g*BE_WIDTH +: BE_WIDTH];
  end

  // Round-robin scan: rotate the requests so bit 0 is the priority pointer
  always_comb begin
    w_req_dbl  = {m_req_i, m_req_i} >> ptr_q;
    w_rr_found = 1'b0;
    w_rr_idx   = ptr_q;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!w_rr_found && w_req_dbl[i]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = ID_W'((int'(ptr_q) + i) % NUM_MASTERS);
      end
    end
  end

  // A pending (ungranted) address phase keeps its master until granted
  assign w_winner = lock_q ? lock_idx_q : w_rr_idx;
  assign w_full   = (count_q == CNT_FULL);
  assign w_head   = fifo_q[rd_ptr_q];

  // Reset gating keeps the request low while m_req_i may still be driven
  assign s_req_o    = rst_ni & ((|m_req_i) | lock_q) & ~w_full;
  assign w_hs       = s_req_o & s_gnt_i;
  assign w_pop      = s_rvalid_i & (count_q != '0);
  assign w_spurious = s_rvalid_i & (count_q == '0);
  assign w_drop     = lock_q & ~m_req_i[lock_idx_q];

  assign s_we_o    = m_we_i[w_winner];
  assign s_be_o    = w_be[w_winner];
  assign s_addr_o  = w_addr[w_winner];
  assign s_wdata_o = w_wdata[w_winner];

  assign m_rdata_o     = s_rdata_i;
  assign outstanding_o = count_q;
  assign err_o         = err_q;

  // Grant and response steering, one-hot or zero
  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    if (w_hs) begin
      m_gnt_o[w_winner] = 1'b1;
    end
    if (w_pop) begin
      m_rvalid_o[w_head] = 1'b1;
    end
  end

  // Next-state: priority pointer, stability lock, FIFO pointers/count, error
  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    err_d      = err_q;

    if (w_hs) begin
      ptr_d  = (w_winner == ID_LAST) ? '0 : w_winner + 1'b1;
      lock_d = 1'b0;
    end else if (w_drop) begin
      // Locked master withdrew before its grant: release the lock
      lock_d = 1'b0;
    end else if (s_req_o && !s_gnt_i) begin
      lock_d     = 1'b1;
      lock_idx_d = w_winner;
    end

    if (w_drop || w_spurious) begin
      err_d = 1'b1;
    end

    if (w_hs) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end

    case ({w_hs, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers and ID FIFO storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      if (w_hs) begin
        fifo_q[wr_ptr_q] <= w_winner;
      end
    end
  end

endmodule
`default_nettype wire
